// File: rtl/trace_pattern_gen.sv
// Multi-channel trace pattern generator: IDLE -> RUN (MAX_CYC advances) -> DONE.
// Define TRACE_PATTERN_GEN_PARITY_EN to add the registered per-channel parity output parity_o.
module trace_pattern_gen #(
  parameter int CH      = 4,
  parameter int W       = 8,
  parameter int MAX_CYC = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [W-1:0]        seed,
  input  logic [2*CH-1:0]     mode,
  output logic [CH*W-1:0]     data_o,
  output logic                valid_o,
  output logic [1:0]          state_o,
  output logic [31:0]         cyc_o,
  output logic                done_o
`ifdef TRACE_PATTERN_GEN_PARITY_EN
  ,
  output logic [CH-1:0]       parity_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] LAST_CYC = 32'(MAX_CYC - 1);

  state_t            state;
  state_t            state_next;
  logic [CH*W-1:0]   seed_data;
  logic [CH*W-1:0]   adv_data;
  logic [CH*W-1:0]   data_next;
  logic [31:0]       cyc_next;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [W-1:0] cur;
    assign cur = data_o[W*c +: W];
    assign seed_data[W*c +: W] = seed + W'(c);

    always_comb begin
      adv_data[W*c +: W] = cur;
      case (mode[2*c +: 2])
        2'b00:   adv_data[W*c +: W] = cur;
        2'b01:   adv_data[W*c +: W] = ~cur;
        2'b10:   adv_data[W*c +: W] = cur + W'(1);
        default: adv_data[W*c +: W] = cur - W'(1);
      endcase
    end
  end

  // Abort is checked before the terminal-advance test so it always wins.
  always_comb begin
    state_next = state;
    data_next  = data_o;
    cyc_next   = cyc_o;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          data_next  = seed_data;
          cyc_next   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
          data_next  = '0;
          cyc_next   = '0;
        end else begin
          data_next = adv_data;
          cyc_next  = cyc_o + 32'd1;
          if (cyc_o == LAST_CYC) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef TRACE_PATTERN_GEN_PARITY_EN
  logic [CH-1:0] parity_next;
  for (genvar c = 0; c < CH; c++) begin : g_par
    assign parity_next[c] = ^data_next[W*c +: W];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      data_o  <= '0;
      cyc_o   <= '0;
      valid_o <= 1'b0;
      done_o  <= 1'b0;
`ifdef TRACE_PATTERN_GEN_PARITY_EN
      parity_o <= '0;
`endif
    end else begin
      state   <= state_next;
      data_o  <= data_next;
      cyc_o   <= cyc_next;
      valid_o <= (state_next == RUN);
      done_o  <= (state_next == DONE);
`ifdef TRACE_PATTERN_GEN_PARITY_EN
      parity_o <= parity_next;
`endif
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_trace_pattern_gen.sv
// Scoreboard bench for trace_pattern_gen (CH=4, W=8, MAX_CYC=6) with hand-computed vectors.
module tb_trace_pattern_gen;
  localparam int CH = 4;
  localparam int W = 8;
  localparam int MAX_CYC = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic          abort;
  logic [7:0]    seed;
  logic [7:0]    mode;
  logic [31:0]   data_o;
  logic          valid_o;
  logic [1:0]    state_o;
  logic [31:0]   cyc_o;
  logic          done_o;
`ifdef TRACE_PATTERN_GEN_PARITY_EN
  logic [3:0]    parity_o;
`endif

  trace_pattern_gen #(.CH(CH), .W(W), .MAX_CYC(MAX_CYC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .seed    (seed),
    .mode    (mode),
    .data_o  (data_o),
    .valid_o (valid_o),
    .state_o (state_o),
    .cyc_o   (cyc_o),
    .done_o  (done_o)
`ifdef TRACE_PATTERN_GEN_PARITY_EN
    ,
    .parity_o(parity_o)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] cyc;
    logic        done;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] packData(input logic [7:0] d0, input logic [7:0] d1,
                                           input logic [7:0] d2, input logic [7:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [3:0] parityOf(input logic [31:0] d);
    logic [3:0] p;
    for (int c = 0; c < 4; c++) p[c] = ^d[8*c +: 8];
    return p;
  endfunction

  task automatic pushExp(input logic [31:0] cyc, input logic done, input logic [7:0] d0,
                         input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
    exp_t e;
    e.data = packData(d0, d1, d2, d3);
    e.cyc  = cyc;
    e.done = done;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    start = s;
    abort = a;
  endtask

  task automatic startPulse(input logic [7:0] sd, input logic [7:0] md);
    tick();
    seed = sd;
    mode = md;
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [1:0] st, input logic [31:0] d,
                             input logic [31:0] cy, input logic v, input logic dn);
    checks++;
    if ({state_o, data_o, cyc_o, valid_o, done_o} !== {st, d, cy, v, dn}) begin
      errors++;
      $display("[TB] FAIL %s: got state=%0d data=%h cyc=%0d valid=%b done=%b, required state=%0d data=%h cyc=%0d valid=%b done=%b",
               name, state_o, data_o, cyc_o, valid_o, done_o, st, d, cy, v, dn);
    end
`ifdef TRACE_PATTERN_GEN_PARITY_EN
    checks++;
    if (parity_o !== parityOf(d)) begin
      errors++;
      $display("[TB] FAIL %s_parity: got %b, required %b", name, parity_o, parityOf(d));
    end
`endif
  endtask

  // Monitor: every cycle with valid_o or done_o must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_o === 1'b1 || done_o === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_output: got state=%0d data=%h cyc=%0d valid=%b done=%b, required no output",
                   state_o, data_o, cyc_o, valid_o, done_o);
        end else begin
          e = q.pop_front();
          if ({state_o, data_o, cyc_o, valid_o, done_o} !==
              {(e.done ? 2'd2 : 2'd1), e.data, e.cyc, ~e.done, e.done}) begin
            errors++;
            $display("[TB] FAIL seq_output: got state=%0d data=%h cyc=%0d valid=%b done=%b, required state=%0d data=%h cyc=%0d valid=%b done=%b",
                     state_o, data_o, cyc_o, valid_o, done_o, (e.done ? 2'd2 : 2'd1), e.data, e.cyc,
                     ~e.done, e.done);
          end
`ifdef TRACE_PATTERN_GEN_PARITY_EN
          checks++;
          if (parity_o !== parityOf(e.data)) begin
            errors++;
            $display("[TB] FAIL seq_parity: got %b, required %b (cyc=%0d)", parity_o, parityOf(e.data), e.cyc);
          end
`endif
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    seed  = 8'h00;
    mode  = 8'h00;
    applyStimulus(1'b1, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    checkOutput("reset", 2'd0, 32'h0, 32'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);

    // Increment on all channels from 0x10.
    for (int k = 0; k < 6; k++)
      pushExp(k, 1'b0, 8'h10 + 8'(k), 8'h11 + 8'(k), 8'h12 + 8'(k), 8'h13 + 8'(k));
    pushExp(6, 1'b1, 8'h16, 8'h17, 8'h18, 8'h19);
    startPulse(8'h10, 8'hAA);
    repeat (7) tick();
    @(negedge clk);
    checkOutput("done_to_idle", 2'd0, packData(8'h16, 8'h17, 8'h18, 8'h19), 32'd6, 1'b0, 1'b0);
    mode = 8'h55;
    repeat (3) tick();
    @(negedge clk);
    checkOutput("idle_hold", 2'd0, packData(8'h16, 8'h17, 8'h18, 8'h19), 32'd6, 1'b0, 1'b0);

    // Wrap: ch0 increments, ch1 decrements, ch2/ch3 hold; reloads over stale data.
    pushExp(0, 1'b0, 8'hFE, 8'hFF, 8'h00, 8'h01);
    pushExp(1, 1'b0, 8'hFF, 8'hFE, 8'h00, 8'h01);
    pushExp(2, 1'b0, 8'h00, 8'hFD, 8'h00, 8'h01);
    pushExp(3, 1'b0, 8'h01, 8'hFC, 8'h00, 8'h01);
    pushExp(4, 1'b0, 8'h02, 8'hFB, 8'h00, 8'h01);
    pushExp(5, 1'b0, 8'h03, 8'hFA, 8'h00, 8'h01);
    pushExp(6, 1'b1, 8'h04, 8'hF9, 8'h00, 8'h01);
    startPulse(8'hFE, 8'h0E);
    repeat (7) tick();
    @(negedge clk);
    checkOutput("wrap_idle", 2'd0, packData(8'h04, 8'hF9, 8'h00, 8'h01), 32'd6, 1'b0, 1'b0);

    // Invert/inc/hold/dec with start held into RUN (must be ignored there).
    pushExp(0, 1'b0, 8'hA5, 8'hA6, 8'hA7, 8'hA8);
    pushExp(1, 1'b0, 8'h5A, 8'hA7, 8'hA7, 8'hA7);
    pushExp(2, 1'b0, 8'hA5, 8'hA8, 8'hA7, 8'hA6);
    pushExp(3, 1'b0, 8'h5A, 8'hA9, 8'hA7, 8'hA5);
    pushExp(4, 1'b0, 8'hA5, 8'hAA, 8'hA7, 8'hA4);
    pushExp(5, 1'b0, 8'h5A, 8'hAB, 8'hA7, 8'hA3);
    pushExp(6, 1'b1, 8'hA5, 8'hAC, 8'hA7, 8'hA2);
    tick();
    seed = 8'hA5;
    mode = 8'hC9;
    applyStimulus(1'b1, 1'b0);
    repeat (3) tick();
    applyStimulus(1'b0, 1'b0);
    repeat (5) tick();
    @(negedge clk);
    checkOutput("invert_idle", 2'd0, packData(8'hA5, 8'hAC, 8'hA7, 8'hA2), 32'd6, 1'b0, 1'b0);

    // Abort together with start at cyc_o=3.
    for (int k = 0; k < 4; k++)
      pushExp(k, 1'b0, 8'h10 + 8'(k), 8'h11 + 8'(k), 8'h12 + 8'(k), 8'h13 + 8'(k));
    startPulse(8'h10, 8'hAA);
    repeat (3) tick();
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abort_idle", 2'd0, 32'h0, 32'd0, 1'b0, 1'b0);
    repeat (4) tick();
    @(negedge clk);
    checkOutput("abort_settled", 2'd0, 32'h0, 32'd0, 1'b0, 1'b0);

    // Abort on the terminal advance (cyc_o=5): ch0 reaches 0x07 first.
    for (int k = 0; k < 6; k++)
      pushExp(k, 1'b0, 8'h02 + 8'(k), 8'h03 + 8'(k), 8'h04 + 8'(k), 8'h05 + 8'(k));
    startPulse(8'h02, 8'hAA);
    repeat (5) tick();
`ifdef TRACE_PATTERN_GEN_PARITY_EN
    checks++;
    if (parity_o[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL parity_ch0_07: got %b, required 1", parity_o[0]);
    end
`endif
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abort_terminal", 2'd0, 32'h0, 32'd0, 1'b0, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    checkOutput("abort_terminal_settled", 2'd0, 32'h0, 32'd0, 1'b0, 1'b0);

    // Reset mid-RUN with start and abort high.
    pushExp(0, 1'b0, 8'h30, 8'h31, 8'h32, 8'h33);
    pushExp(1, 1'b0, 8'hCF, 8'hCE, 8'hCD, 8'hCC);
    startPulse(8'h30, 8'h55);
    tick();
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1);
    tick();
    @(negedge clk);
    checkOutput("reset_mid_run", 2'd0, 32'h0, 32'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    checkOutput("after_reset_idle", 2'd0, 32'h0, 32'd0, 1'b0, 1'b0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_outputs: got %0d unconsumed expectations, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
